fetch_ras: RTL and testbench
============================

# fetch_ras

Return address stack for the fetch unit's return prediction. On a BTB hit with a JUMP_L/INDIRECT_L action it pushes the link PC; on a RET/RET_L action it supplies the predicted return target (`ret_pc38`) for the fast-redirect path and pops. It exports its stack pointer and occupancy every cycle so the BCB can checkpoint `{gh, ras_idx, ras_cnt}`. It accepts a restore from a BCB entry on a mispredict or restart.

## Interface
- `RAS_ENTRIES`, default 16: stack depth, a power of 2.
- `LOG_RAS_ENTRIES`, default 4: `$clog2(RAS_ENTRIES)`.
- `CLK`  in  1  clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `valid_push`  in  1  push request this cycle.
- `push_pc38`  in  38  link address to push (pc38_t).
- `valid_pop`  in  1  pop request this cycle.
- `ret_valid`  out  1  stack non-empty; `ret_pc38` is meaningful.
- `ret_pc38`  out  38  current top-of-stack entry.
- `ras_idx`  out  LOG_RAS_ENTRIES  current next-push slot (ras_idx_t), exported for BCB checkpoint.
- `ras_cnt`  out  LOG_RAS_ENTRIES+1  current valid-entry count, 0..RAS_ENTRIES (ras_cnt_t).
- `valid_restore`  in  1  restore the pointer state from a BCB entry.
- `restore_ras_idx`  in  LOG_RAS_ENTRIES  restored stack pointer.
- `restore_ras_cnt`  in  LOG_RAS_ENTRIES+1  restored count.

## Operation
- State:
  - `sp` (ras_idx_t) is the next push slot; top entry is `array[sp-1]`, with wrap-around modulo RAS_ENTRIES.
  - `cnt` (ras_cnt_t) is saturating at RAS_ENTRIES.
  - `array` holds RAS_ENTRIES × pc38_t.
- Outputs are combinational from current state only and never depend on the same-cycle inputs:
  - `ret_pc38` = `array[sp-1]`.
  - `ret_valid` = `(cnt != 0)`.
  - `ras_idx` = `sp`.
  - `ras_cnt` = `cnt`.
- Priority and next-state, evaluated per cycle:
  - **`valid_restore`**: `sp` ← `restore_ras_idx`, `cnt` ← `restore_ras_cnt`. Push and pop in the same cycle are ignored. `array` is unchanged. Entries overwritten after the checkpoint are not repaired.
  - **Push only**: `array[sp]` ← `push_pc38`, `sp` ← `sp+1` (wraps 15→0), `cnt` ← `min(cnt+1, RAS_ENTRIES)`.
    - Overflow (`cnt == RAS_ENTRIES`) silently overwrites the oldest entry; `cnt` stays at RAS_ENTRIES.
  - **Pop only, `cnt != 0`**: `sp` ← `sp-1` (wraps 0→15), `cnt` ← `cnt-1`.
  - **Pop only, `cnt == 0`**: no state change (underflow ignored).
  - **Push and pop together (RET_L / coroutine swap)**:
    - `cnt != 0`: `array[sp-1]` ← `push_pc38`; `sp` and `cnt` are unchanged.
    - `cnt == 0`: behaves as push only.
  - **Neither**: hold.
- `restore_ras_cnt` above RAS_ENTRIES is illegal input; the result is undefined and is flagged by an assertion in the bench.
- Reset (`nRST` low, asynchronous): `sp` = 0, `cnt` = 0, all `array` entries = INIT_PC38 (38'h0). At reset, `ret_valid` = 0, `ret_pc38` = 0, `ras_idx` = 0, `ras_cnt` = 0.
  - Reset asserted mid-operation discards all pending and in-flight state immediately.
  - The first push is accepted on the first rising `CLK` after `nRST` deasserts.

## Timing
- Zero-cycle read: `ret_pc38`, `ret_valid`, `ras_idx` and `ras_cnt` reflect state after the last clock edge. A pop consumes the value presented in the same cycle.
- Single-cycle update: a push, pop or restore is visible on the outputs the cycle after.
- Push, pop and restore may arrive every cycle with no back-pressure.
- The BCB captures `ras_idx`/`ras_cnt` in the same cycle as the branch prediction, i.e. pre-update values.
- All state registers are clocked on the rising edge of `CLK` and asynchronously cleared on `nRST` low.

## Test plan
- **Reset:** hold `nRST` low, then release.
  - Outputs are `ret_valid`=0, `ret_pc38`=0, `ras_idx`=0, `ras_cnt`=0.
  - A pop on the first cycle leaves the state unchanged.
- **Push/pop LIFO:** push 38'h100, then 38'h200, then 38'h300 on consecutive cycles.
  - `ret_pc38` reads 300, 200, 100 across three pops.
  - `ras_cnt` goes 3→2→1→0; `ret_valid` drops after the third pop.
- **Overflow:** push 17 values (38'h1 … 38'h11).
  - `ras_cnt` saturates at 16; `ras_idx` = 1.
  - 16 pops return 38'h11 down to 38'h2; the 17th pop is ignored with `cnt`=0.
- **Simultaneous push+pop:**
  - Start with stack [A=38'hA, B=38'hB (top)]; assert both with `push_pc38` = 38'hC. `ret_pc38` shows B during that cycle. Next cycle the top is C, `ras_cnt`=2, `ras_idx` is unchanged.
  - Repeat on an empty stack: result equals a single push, `ras_cnt`=1.
- **Restore priority:** after pushing 38'h10, 38'h20, 38'h30 (`idx`=3, `cnt`=3), assert `valid_restore` (`idx`=1, `cnt`=1) together with push 38'h99.
  - Next cycle: `ras_idx`=1, `ras_cnt`=1, `ret_pc38`=38'h10; entry 3 is not written.
- **Wrap and async reset:**
  - Alternate pushes and pops to cross `sp` 15→0 and 0→15, checking `ret_pc38` against a reference model.
  - Assert `nRST` mid-burst, asynchronously between edges: outputs clear immediately.

Source files
------------

// File: rtl/fetch_ras_if.sv
`default_nettype none
// ==========================================================================
// fetch_ras_if : push/pop/restore and prediction bus of the fetch RAS  (rev 1.0)
// ==========================================================================
interface fetch_ras_if #(
  parameter int LOG_RAS_ENTRIES = 4
);
  logic                       valid_push;
  logic [37:0]                push_pc38;
  logic                       valid_pop;
  logic                       valid_restore;
  logic [LOG_RAS_ENTRIES-1:0] restore_ras_idx;
  logic [LOG_RAS_ENTRIES:0]   restore_ras_cnt;
  logic                       ret_valid;
  logic [37:0]                ret_pc38;
  logic [LOG_RAS_ENTRIES-1:0] ras_idx;
  logic [LOG_RAS_ENTRIES:0]   ras_cnt;

  modport master (
    output valid_push, push_pc38, valid_pop,
    output valid_restore, restore_ras_idx, restore_ras_cnt,
    input  ret_valid, ret_pc38, ras_idx, ras_cnt
  );

  modport slave (
    input  valid_push, push_pc38, valid_pop,
    input  valid_restore, restore_ras_idx, restore_ras_cnt,
    output ret_valid, ret_pc38, ras_idx, ras_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ras.sv
`default_nettype none
// ==========================================================================
// fetch_ras : circular return address stack with BCB checkpoint restore  (rev 1.0)
// ==========================================================================
module fetch_ras #(
  parameter int RAS_ENTRIES     = 16,
  parameter int LOG_RAS_ENTRIES = 4
) (
  input  wire logic     CLK,
  input  wire logic     nRST,
  fetch_ras_if.slave    ras
);
  localparam logic [37:0]                c_init_pc38 = 38'h0;
  localparam logic [LOG_RAS_ENTRIES-1:0] c_idx_one   = LOG_RAS_ENTRIES'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   c_cnt_one   = (LOG_RAS_ENTRIES+1)'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   c_cnt_zero  = '0;
  localparam logic [LOG_RAS_ENTRIES:0]   c_cnt_max   = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

  logic [37:0]                r_array [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0] r_sp;
  logic [LOG_RAS_ENTRIES:0]   r_cnt;

  logic [LOG_RAS_ENTRIES-1:0] w_sp_m1;
  logic [LOG_RAS_ENTRIES-1:0] w_sp_next;
  logic [LOG_RAS_ENTRIES:0]   w_cnt_next;
  logic                       w_wr_en;
  logic [LOG_RAS_ENTRIES-1:0] w_wr_idx;
  logic                       w_nonempty;

  assign w_sp_m1    = r_sp - c_idx_one;
  assign w_nonempty = (r_cnt != c_cnt_zero);

  // Restore wins over everything; a push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    w_sp_next  = r_sp;
    w_cnt_next = r_cnt;
    w_wr_en    = 1'b0;
    w_wr_idx   = r_sp;
    if (ras.valid_restore) begin
      w_sp_next  = ras.restore_ras_idx;
      w_cnt_next = ras.restore_ras_cnt;
    end else if (ras.valid_push && ras.valid_pop && w_nonempty) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_sp_m1;
    end else if (ras.valid_push) begin
      w_wr_en    = 1'b1;
      w_wr_idx   = r_sp;
      w_sp_next  = r_sp + c_idx_one;
      w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;
    end else if (ras.valid_pop && w_nonempty) begin
      w_sp_next  = w_sp_m1;
      w_cnt_next = r_cnt - c_cnt_one;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else begin
      r_sp  <= w_sp_next;
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        r_array[i] <= c_init_pc38;
      end
    end else if (w_wr_en) begin
      r_array[w_wr_idx] <= ras.push_pc38;
    end
  end

  assign ras.ret_pc38  = r_array[w_sp_m1];
  assign ras.ret_valid = w_nonempty;
  assign ras.ras_idx   = r_sp;
  assign ras.ras_cnt   = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_fetch_ras.sv
`default_nettype none
// ==========================================================================
// tb_fetch_ras : scoreboard bench for fetch_ras against a reference stack  (rev 1.0)
// ==========================================================================
module tb_fetch_ras;
  logic CLK;
  logic nRST;

  fetch_ras_if #(.LOG_RAS_ENTRIES(4)) bus ();

  fetch_ras #(.RAS_ENTRIES(16), .LOG_RAS_ENTRIES(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .ras  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [37:0] pc;
    logic [3:0]  idx;
    logic [4:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [37:0] m_arr [16];
  logic [3:0]  m_sp;
  logic [4:0]  m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(posedge CLK) begin
    if (nRST && bus.valid_restore)
      assert (bus.restore_ras_cnt <= 5'd16)
        else $error("FAIL restore_cnt_range: got %0d required <= 16", bus.restore_ras_cnt);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_arr[i] = '0;
    m_sp  = '0;
    m_cnt = '0;
  endtask

  task automatic model_step(input logic push, input logic [37:0] pc, input logic pop,
                            input logic rv, input logic [3:0] ridx, input logic [4:0] rcnt);
    if (rv) begin
      m_sp  = ridx;
      m_cnt = rcnt;
    end else if (push && pop && m_cnt != 0) begin
      m_arr[m_sp - 4'd1] = pc;
    end else if (push) begin
      m_arr[m_sp] = pc;
      m_sp  = m_sp + 4'd1;
      if (m_cnt < 5'd16) m_cnt = m_cnt + 5'd1;
    end else if (pop && m_cnt != 0) begin
      m_sp  = m_sp - 4'd1;
      m_cnt = m_cnt - 5'd1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.v   = (m_cnt != 0);
    e.pc  = m_arr[m_sp - 4'd1];
    e.idx = m_sp;
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic idle_inputs();
    bus.valid_push      = 1'b0;
    bus.push_pc38       = '0;
    bus.valid_pop       = 1'b0;
    bus.valid_restore   = 1'b0;
    bus.restore_ras_idx = '0;
    bus.restore_ras_cnt = '0;
  endtask

  // Called at a falling edge; drives one cycle, then scores the post-edge outputs.
  task automatic step(input logic push, input logic [37:0] pc, input logic pop,
                      input logic rv = 1'b0, input logic [3:0] ridx = '0,
                      input logic [4:0] rcnt = '0);
    exp_t e;
    bus.valid_push      = push;
    bus.push_pc38       = pc;
    bus.valid_pop       = pop;
    bus.valid_restore   = rv;
    bus.restore_ras_idx = ridx;
    bus.restore_ras_cnt = rcnt;
    model_step(push, pc, pop, rv, ridx, rcnt);
    sb_q.push_back(model_out());
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check("sb_ret_valid", 64'(bus.ret_valid), 64'(e.v));
    check("sb_ret_pc38",  64'(bus.ret_pc38),  64'(e.pc));
    check("sb_ras_idx",   64'(bus.ras_idx),   64'(e.idx));
    check("sb_ras_cnt",   64'(bus.ras_cnt),   64'(e.cnt));
    idle_inputs();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.ret_valid), 64'd0);
    check({tag, "_pc"},    64'(bus.ret_pc38),  64'd0);
    check({tag, "_idx"},   64'(bus.ras_idx),   64'd0);
    check({tag, "_cnt"},   64'(bus.ras_cnt),   64'd0);
  endtask

  initial begin
    logic [37:0] pc;
    logic        op;
    idle_inputs();
    nRST = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    do_reset();
    step(1'b0, '0, 1'b1);
    check_zero("pop_after_reset");

    // LIFO ordering
    step(1'b1, 38'h100, 1'b0);
    step(1'b1, 38'h200, 1'b0);
    step(1'b1, 38'h300, 1'b0);
    check("lifo_top", 64'(bus.ret_pc38), 64'h300);
    step(1'b0, '0, 1'b1);
    check("lifo_pop1", 64'(bus.ret_pc38), 64'h200);
    step(1'b0, '0, 1'b1);
    check("lifo_pop2", 64'(bus.ret_pc38), 64'h100);
    step(1'b0, '0, 1'b1);
    check("lifo_empty_valid", 64'(bus.ret_valid), 64'd0);
    check("lifo_empty_cnt",   64'(bus.ras_cnt),   64'd0);

    // Overflow: 17 pushes wrap and overwrite the oldest
    do_reset();
    for (int i = 1; i <= 17; i++) step(1'b1, 38'(i), 1'b0);
    check("ovf_cnt", 64'(bus.ras_cnt), 64'd16);
    check("ovf_idx", 64'(bus.ras_idx), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check("ovf_pop_val", 64'(bus.ret_pc38), 64'(17 - i));
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b1);
    check("underflow_cnt", 64'(bus.ras_cnt), 64'd0);

    // Simultaneous push+pop
    do_reset();
    step(1'b1, 38'hA, 1'b0);
    step(1'b1, 38'hB, 1'b0);
    bus.valid_push = 1'b1;
    bus.push_pc38  = 38'hC;
    bus.valid_pop  = 1'b1;
    #1;
    check("swap_same_cycle", 64'(bus.ret_pc38), 64'hB);
    step(1'b1, 38'hC, 1'b1);
    check("swap_top", 64'(bus.ret_pc38), 64'hC);
    check("swap_cnt", 64'(bus.ras_cnt),  64'd2);
    check("swap_idx", 64'(bus.ras_idx),  64'd2);
    do_reset();
    step(1'b1, 38'hC, 1'b1);
    check("swap_empty_cnt", 64'(bus.ras_cnt),  64'd1);
    check("swap_empty_top", 64'(bus.ret_pc38), 64'hC);

    // Restore priority over a same-cycle push
    do_reset();
    step(1'b1, 38'h10, 1'b0);
    step(1'b1, 38'h20, 1'b0);
    step(1'b1, 38'h30, 1'b0);
    step(1'b1, 38'h99, 1'b0, 1'b1, 4'd1, 5'd1);
    check("restore_idx", 64'(bus.ras_idx),  64'd1);
    check("restore_cnt", 64'(bus.ras_cnt),  64'd1);
    check("restore_top", 64'(bus.ret_pc38), 64'h10);
    step(1'b0, '0, 1'b0, 1'b1, 4'd4, 5'd4);
    check("restore_entry3_untouched", 64'(bus.ret_pc38), 64'd0);

    // Wrap across 15->0 and 0->15 with mixed traffic
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 38'(32'h1000 + i), 1'b0);
    for (int i = 0; i < 60; i++) begin
      pc = {6'd0, $urandom};
      op = 1'($urandom_range(0, 1));
      step(op, pc, ~op | (($urandom_range(0, 3)) == 0));
    end
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 38'(32'h2000 + i), 1'b0);

    // Asynchronous reset between edges clears outputs at once
    bus.valid_push = 1'b1;
    bus.push_pc38  = 38'h3F;
    #2;
    nRST = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    step(1'b1, 38'h55, 1'b0);
    check("first_push_after_reset", 64'(bus.ret_pc38), 64'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
